// File: rtl/ram_pkg.sv
// Shared types for the true-dual-port tensor RAM bank.
//   wmode_e     : same-port read-during-write behaviour
//   clr_state_e : zero-fill sequencer states
//   BYTES       : byte lanes of the default 16-bit word
package ram_pkg;

   typedef enum logic [1:0] {
      READ_FIRST  = 2'd0,
      WRITE_FIRST = 2'd1,
      NO_CHANGE   = 2'd2
   } wmode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned BYTES          = DATA_WIDTH_DEF / 8;

endpackage

// File: rtl/ram_tdp_bank_if.sv
// One RAM access port.
//   en   : port enable
//   we   : byte-lane write enable (all zero = read)
//   addr : word address
//   din  : write data
//   dout : read data
//   vld  : read data valid
// master = requester (im2col writer / GEMM fetch), slave = RAM bank.
interface ram_tdp_bank_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_W     = 10
);
   logic                    en;
   logic [DATA_WIDTH/8-1:0] we;
   logic [ADDR_W-1:0]       addr;
   logic [DATA_WIDTH-1:0]   din;
   logic [DATA_WIDTH-1:0]   dout;
   logic                    vld;

   modport master (output en, we, addr, din, input  dout, vld);
   modport slave  (input  en, we, addr, din, output dout, vld);
endinterface

// File: rtl/ram_rd_pipe.sv
// Per-port read-data delay line.
//   clka, rst_n : clock, async active-low reset
//   req         : read data on 'data' is to be delivered
//   data        : word captured in the access cycle
//   dout, vld   : delivered READ_LATENCY cycles later; dout holds between reads
module ram_rd_pipe #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clka,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  vld
);

   logic [DATA_WIDTH-1:0] d1_q;
   logic                  v1_q;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         d1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         v1_q <= req;
         if (req) d1_q <= data;
      end
   end

   if (READ_LATENCY >= 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] d2_q;
      logic                  v2_q;

      always_ff @(posedge clka or negedge rst_n) begin
         if (!rst_n) begin
            d2_q <= '0;
            v2_q <= 1'b0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) d2_q <= d1_q;
         end
      end

      assign dout = d2_q;
      assign vld  = v2_q;
   end else begin : g_lat1
      assign dout = d1_q;
      assign vld  = v1_q;
   end

endmodule

// File: rtl/ram_tdp_bank.sv
// True-dual-port RAM bank for the IMG2COL datapath.
//   clka, rst_n : clock, async active-low reset
//   pa          : port A (im2col writer / reloader)
//   pb          : port B (GEMM operand fetch)
//   clr_req     : start zero-fill (sampled while idle)
//   busy        : zero-fill in progress, port requests ignored
//   coll        : pulse, both ports hit the same address with a write
//   oob         : pulse, an accepted address was out of range
module ram_tdp_bank
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned ADDR_W       = $clog2(DEPTH),
   parameter int unsigned READ_LATENCY = 1,
   parameter wmode_e      WRITE_MODE   = READ_FIRST,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic          clka,
   input  logic          rst_n,
   ram_tdp_bank_if.slave pa,
   ram_tdp_bank_if.slave pb,
   input  logic          clr_req,
   output logic          busy,
   output logic          coll,
   output logic          oob
);

   localparam int unsigned LANES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              coll_q, oob_q;

   logic                  acc_a, acc_b, ok_a, ok_b, wr_a, wr_b, same;
   logic                  rd_req_a, rd_req_b;
   logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

   assign busy  = (state_q != IDLE);
   assign acc_a = pa.en & ~busy;
   assign acc_b = pb.en & ~busy;
   assign ok_a  = acc_a & (32'(pa.addr) < DEPTH);
   assign ok_b  = acc_b & (32'(pb.addr) < DEPTH);
   assign wr_a  = ok_a & (|pa.we);
   assign wr_b  = ok_b & (|pb.we);
   assign same  = ok_a & ok_b & (pa.addr == pb.addr);

   assign old_a = mem[pa.addr];
   assign old_b = mem[pb.addr];

   // Final post-write word seen from each port. On a same-address double write both
   // ports compute the identical word: A owns shared lanes, each port owns its own.
   always_comb begin
      new_a = old_a;
      new_b = old_b;
      for (int i = 0; i < LANES; i++) begin
         if (pa.we[i])                new_a[8*i +: 8] = pa.din[8*i +: 8];
         else if (same && pb.we[i])   new_a[8*i +: 8] = pb.din[8*i +: 8];
         if (same && pa.we[i])        new_b[8*i +: 8] = pa.din[8*i +: 8];
         else if (pb.we[i])           new_b[8*i +: 8] = pb.din[8*i +: 8];
      end
   end

   // Cross-port readers always see old_x (pre-write); only the writing port may
   // observe the new word, and only in WRITE_FIRST.
   assign rd_a     = (wr_a && WRITE_MODE == WRITE_FIRST) ? new_a : old_a;
   assign rd_b     = (wr_b && WRITE_MODE == WRITE_FIRST) ? new_b : old_b;
   assign rd_req_a = ok_a & ~(wr_a && WRITE_MODE == NO_CHANGE);
   assign rd_req_b = ok_b & ~(wr_b && WRITE_MODE == NO_CHANGE);

   always_ff @(posedge clka) begin
      if (state_q == CLEAR) begin
         mem[clr_cnt_q] <= '0;
      end else begin
         if (wr_a) mem[pa.addr] <= new_a;
         if (wr_b) mem[pb.addr] <= new_b;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         IDLE: begin
            clr_cnt_d = '0;
            if (clr_req) state_d = CLEAR;
         end
         CLEAR: begin
            if (32'(clr_cnt_q) == DEPTH - 1) state_d = DONE;
            else                             clr_cnt_d = clr_cnt_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR_ON_RST ? CLEAR : IDLE;
         clr_cnt_q <= '0;
         coll_q    <= 1'b0;
         oob_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         coll_q    <= same & (wr_a | wr_b);
         oob_q     <= (acc_a & ~ok_a) | (acc_b & ~ok_b);
      end
   end

   assign coll = coll_q;
   assign oob  = oob_q;

   ram_rd_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_pipe_a (
      .clka (clka),
      .rst_n(rst_n),
      .req  (rd_req_a),
      .data (rd_a),
      .dout (pa.dout),
      .vld  (pa.vld)
   );

   ram_rd_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_pipe_b (
      .clka (clka),
      .rst_n(rst_n),
      .req  (rd_req_b),
      .data (rd_b),
      .dout (pb.dout),
      .vld  (pb.vld)
   );

endmodule

// File: tb/tb_ram_tdp_bank.sv
// Directed bench for ram_tdp_bank.
//   u0: DEPTH 16, latency 1, READ_FIRST   (main instance)
//   u1: DEPTH 16, latency 2, WRITE_FIRST
//   u2: DEPTH 16, latency 1, NO_CHANGE
//   u3: DEPTH 12, latency 1, READ_FIRST   (out-of-range)
module tb_ram_tdp_bank;
   import ram_pkg::*;

   logic       clka  = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] clr   = '0;
   logic [3:0] busy, coll, oob;
   int         checks = 0;
   int         errors = 0;

   always #5 clka = ~clka;

   ram_tdp_bank_if #(.DATA_WIDTH(16), .ADDR_W(4)) a0 (), b0 (), a1 (), b1 (),
                                                   a2 (), b2 (), a3 (), b3 ();

   ram_tdp_bank #(.DATA_WIDTH(16), .DEPTH(16), .READ_LATENCY(1), .WRITE_MODE(READ_FIRST),
                  .CLEAR_ON_RST(1'b1))
      u0 (.clka(clka), .rst_n(rst_n), .pa(a0), .pb(b0), .clr_req(clr[0]), .busy(busy[0]),
          .coll(coll[0]), .oob(oob[0]));
   ram_tdp_bank #(.DATA_WIDTH(16), .DEPTH(16), .READ_LATENCY(2), .WRITE_MODE(WRITE_FIRST),
                  .CLEAR_ON_RST(1'b1))
      u1 (.clka(clka), .rst_n(rst_n), .pa(a1), .pb(b1), .clr_req(clr[1]), .busy(busy[1]),
          .coll(coll[1]), .oob(oob[1]));
   ram_tdp_bank #(.DATA_WIDTH(16), .DEPTH(16), .READ_LATENCY(1), .WRITE_MODE(NO_CHANGE),
                  .CLEAR_ON_RST(1'b1))
      u2 (.clka(clka), .rst_n(rst_n), .pa(a2), .pb(b2), .clr_req(clr[2]), .busy(busy[2]),
          .coll(coll[2]), .oob(oob[2]));
   ram_tdp_bank #(.DATA_WIDTH(16), .DEPTH(12), .READ_LATENCY(1), .WRITE_MODE(READ_FIRST),
                  .CLEAR_ON_RST(1'b1))
      u3 (.clka(clka), .rst_n(rst_n), .pa(a3), .pb(b3), .clr_req(clr[3]), .busy(busy[3]),
          .coll(coll[3]), .oob(oob[3]));

   task automatic idle_all();
      a0.en = 0; a0.we = '0; a0.addr = '0; a0.din = '0;
      b0.en = 0; b0.we = '0; b0.addr = '0; b0.din = '0;
      a1.en = 0; a1.we = '0; a1.addr = '0; a1.din = '0;
      b1.en = 0; b1.we = '0; b1.addr = '0; b1.din = '0;
      a2.en = 0; a2.we = '0; a2.addr = '0; a2.din = '0;
      b2.en = 0; b2.we = '0; b2.addr = '0; b2.din = '0;
      a3.en = 0; a3.we = '0; a3.addr = '0; a3.din = '0;
      b3.en = 0; b3.we = '0; b3.addr = '0; b3.din = '0;
   endtask

   task automatic drv_a0(input logic en, input logic [1:0] we, input logic [3:0] ad,
                         input logic [15:0] d);
      a0.en = en; a0.we = we; a0.addr = ad; a0.din = d;
   endtask

   task automatic drv_b0(input logic en, input logic [1:0] we, input logic [3:0] ad,
                         input logic [15:0] d);
      b0.en = en; b0.we = we; b0.addr = ad; b0.din = d;
   endtask

   task automatic drv_a1(input logic en, input logic [1:0] we, input logic [3:0] ad,
                         input logic [15:0] d);
      a1.en = en; a1.we = we; a1.addr = ad; a1.din = d;
   endtask

   task automatic drv_a2(input logic en, input logic [1:0] we, input logic [3:0] ad,
                         input logic [15:0] d);
      a2.en = en; a2.we = we; a2.addr = ad; a2.din = d;
   endtask

   task automatic drv_a3(input logic en, input logic [1:0] we, input logic [3:0] ad,
                         input logic [15:0] d);
      a3.en = en; a3.we = we; a3.addr = ad; a3.din = d;
   endtask

   // Counts negedge samples with u0 busy high, starting at the next negedge.
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clka);
         if (busy[0]) n++;
         else break;
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 0;
      idle_all();
      repeat (2) @(negedge clka);
      checks++;
      if (a0.dout !== 16'h0 || a0.vld !== 1'b0 || b0.dout !== 16'h0 || b0.vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_ports: douta=%h vlda=%b doutb=%h vldb=%b, required all 0",
                  a0.dout, a0.vld, b0.dout, b0.vld);
      end
      checks++;
      if (coll[0] !== 1'b0 || oob[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: coll=%b oob=%b, required 0 0", coll[0], oob[0]);
      end
      checks++;
      if (busy !== 4'b1111) begin
         errors++;
         $display("FAIL reset_busy: busy=%b, required 1111", busy);
      end
      @(posedge clka);
      #1 rst_n = 1;
      count_busy(n);
      checks++;
      if (n !== 17) begin
         errors++;
         $display("FAIL reset_clear_len: busy cycles=%0d, required 17", n);
      end
      for (int i = 0; i < 16; i++) begin
         drv_a0(1, 2'b00, 4'(i), 16'h0);
         b1.en = 1; b1.we = '0; b1.addr = 4'(i);
         @(negedge clka);
         idle_all();
         checks++;
         if (a0.vld !== 1'b1 || a0.dout !== 16'h0) begin
            errors++;
            $display("FAIL clear_read_a addr %0d: vld=%b dout=%h, required 1 0000", i, a0.vld,
                     a0.dout);
         end
         checks++;
         if (b1.vld !== 1'b0) begin
            errors++;
            $display("FAIL lat2_early addr %0d: vld=%b, required 0", i, b1.vld);
         end
         @(negedge clka);
         checks++;
         if (a0.vld !== 1'b0) begin
            errors++;
            $display("FAIL lat1_single addr %0d: vld=%b, required 0", i, a0.vld);
         end
         checks++;
         if (b1.vld !== 1'b1 || b1.dout !== 16'h0) begin
            errors++;
            $display("FAIL lat2_read addr %0d: vld=%b dout=%h, required 1 0000", i, b1.vld,
                     b1.dout);
         end
      end
   endtask

   task automatic test_byte_lanes();
      drv_a0(1, 2'b11, 4'd5, 16'hABCD);
      @(negedge clka);
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h0000) begin
         errors++;
         $display("FAIL lanes_wr1_rf: vld=%b dout=%h, required 1 0000", a0.vld, a0.dout);
      end
      drv_a0(1, 2'b10, 4'd5, 16'h1200);
      @(negedge clka);
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'hABCD) begin
         errors++;
         $display("FAIL lanes_wr2_rf: vld=%b dout=%h, required 1 abcd", a0.vld, a0.dout);
      end
      drv_a0(1, 2'b00, 4'd5, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h12CD) begin
         errors++;
         $display("FAIL lanes_merge: vld=%b dout=%h, required 1 12cd", a0.vld, a0.dout);
      end
   endtask

   task automatic test_write_mode();
      // READ_FIRST
      drv_a0(1, 2'b11, 4'd3, 16'h1111);
      @(negedge clka);
      drv_a0(1, 2'b11, 4'd3, 16'h2222);
      @(negedge clka);
      idle_all();
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h1111) begin
         errors++;
         $display("FAIL wm_read_first: vld=%b dout=%h, required 1 1111", a0.vld, a0.dout);
      end
      // WRITE_FIRST, latency 2
      drv_a1(1, 2'b11, 4'd3, 16'h1111);
      @(negedge clka);
      drv_a1(1, 2'b11, 4'd3, 16'h2222);
      @(negedge clka);
      idle_all();
      checks++;
      if (a1.vld !== 1'b1 || a1.dout !== 16'h1111) begin
         errors++;
         $display("FAIL wm_write_first_1: vld=%b dout=%h, required 1 1111", a1.vld, a1.dout);
      end
      @(negedge clka);
      checks++;
      if (a1.vld !== 1'b1 || a1.dout !== 16'h2222) begin
         errors++;
         $display("FAIL wm_write_first_2: vld=%b dout=%h, required 1 2222", a1.vld, a1.dout);
      end
      @(negedge clka);
      checks++;
      if (a1.vld !== 1'b0 || a1.dout !== 16'h2222) begin
         errors++;
         $display("FAIL wm_write_first_hold: vld=%b dout=%h, required 0 2222", a1.vld, a1.dout);
      end
      // NO_CHANGE
      drv_a2(1, 2'b11, 4'd3, 16'h1111);
      @(negedge clka);
      checks++;
      if (a2.vld !== 1'b0 || a2.dout !== 16'h0000) begin
         errors++;
         $display("FAIL wm_no_change_1: vld=%b dout=%h, required 0 0000", a2.vld, a2.dout);
      end
      drv_a2(1, 2'b00, 4'd3, 16'h0);
      @(negedge clka);
      checks++;
      if (a2.vld !== 1'b1 || a2.dout !== 16'h1111) begin
         errors++;
         $display("FAIL wm_no_change_rd1: vld=%b dout=%h, required 1 1111", a2.vld, a2.dout);
      end
      drv_a2(1, 2'b11, 4'd3, 16'h2222);
      @(negedge clka);
      checks++;
      if (a2.vld !== 1'b0 || a2.dout !== 16'h1111) begin
         errors++;
         $display("FAIL wm_no_change_2: vld=%b dout=%h, required 0 1111", a2.vld, a2.dout);
      end
      drv_a2(1, 2'b00, 4'd3, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a2.vld !== 1'b1 || a2.dout !== 16'h2222) begin
         errors++;
         $display("FAIL wm_no_change_rd2: vld=%b dout=%h, required 1 2222", a2.vld, a2.dout);
      end
   endtask

   task automatic test_collision();
      drv_a0(1, 2'b11, 4'd7, 16'hAAAA);
      drv_b0(1, 2'b01, 4'd7, 16'h5555);
      @(negedge clka);
      idle_all();
      checks++;
      if (coll[0] !== 1'b1) begin
         errors++;
         $display("FAIL coll_ww_pulse: coll=%b, required 1", coll[0]);
      end
      drv_a0(1, 2'b00, 4'd7, 16'h0);
      @(negedge clka);
      checks++;
      if (coll[0] !== 1'b0) begin
         errors++;
         $display("FAIL coll_ww_once: coll=%b, required 0", coll[0]);
      end
      checks++;
      if (a0.dout !== 16'hAAAA) begin
         errors++;
         $display("FAIL coll_ww_data: mem[7]=%h, required aaaa", a0.dout);
      end
      // Disjoint lanes: A owns the high byte, B the low byte.
      drv_a0(1, 2'b10, 4'd8, 16'hAAAA);
      drv_b0(1, 2'b01, 4'd8, 16'h5555);
      @(negedge clka);
      idle_all();
      checks++;
      if (coll[0] !== 1'b1) begin
         errors++;
         $display("FAIL coll_lanes_pulse: coll=%b, required 1", coll[0]);
      end
      drv_b0(1, 2'b00, 4'd8, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (b0.vld !== 1'b1 || b0.dout !== 16'hAA55) begin
         errors++;
         $display("FAIL coll_lanes_data: vld=%b mem[8]=%h, required 1 aa55", b0.vld, b0.dout);
      end
      // A writes, B reads same address: B gets old data.
      drv_a0(1, 2'b11, 4'd7, 16'h1234);
      drv_b0(1, 2'b00, 4'd7, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (b0.vld !== 1'b1 || b0.dout !== 16'hAAAA || coll[0] !== 1'b1) begin
         errors++;
         $display("FAIL coll_wr_rd: vldb=%b doutb=%h coll=%b, required 1 aaaa 1", b0.vld,
                  b0.dout, coll[0]);
      end
      // B writes, A reads same address: A gets old data.
      drv_b0(1, 2'b11, 4'd7, 16'h4321);
      drv_a0(1, 2'b00, 4'd7, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h1234 || coll[0] !== 1'b1) begin
         errors++;
         $display("FAIL coll_rd_wr: vlda=%b douta=%h coll=%b, required 1 1234 1", a0.vld,
                  a0.dout, coll[0]);
      end
      // Both read: no collision.
      drv_a0(1, 2'b00, 4'd7, 16'h0);
      drv_b0(1, 2'b00, 4'd7, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (coll[0] !== 1'b0 || a0.dout !== 16'h4321 || b0.dout !== 16'h4321) begin
         errors++;
         $display("FAIL coll_rr: coll=%b douta=%h doutb=%h, required 0 4321 4321", coll[0],
                  a0.dout, b0.dout);
      end
   endtask

   task automatic test_clear_interplay();
      int n;
      drv_a0(1, 2'b11, 4'd2, 16'hBEEF);
      @(negedge clka);
      drv_a0(1, 2'b00, 4'd2, 16'h0);
      clr[0] = 1;
      @(negedge clka);
      clr[0] = 0;
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'hBEEF || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL clr_inflight: vld=%b dout=%h busy=%b, required 1 beef 1", a0.vld,
                  a0.dout, busy[0]);
      end
      n = 1;
      drv_a0(1, 2'b11, 4'd0, 16'h7777);
      drv_b0(1, 2'b00, 4'd2, 16'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clka);
         if (busy[0]) n++;
         checks++;
         if (a0.vld !== 1'b0 || b0.vld !== 1'b0) begin
            errors++;
            $display("FAIL clr_drop %0d: vlda=%b vldb=%b, required 0 0", k, a0.vld, b0.vld);
         end
         clr[0] = (k == 1);
      end
      idle_all();
      clr[0] = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clka);
         if (busy[0]) n++;
         else break;
      end
      checks++;
      if (n !== 17) begin
         errors++;
         $display("FAIL clr_len: busy cycles=%0d, required 17", n);
      end
      repeat (2) @(negedge clka);
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL clr_not_queued: busy=%b, required 0", busy[0]);
      end
      drv_a0(1, 2'b00, 4'd0, 16'h0);
      @(negedge clka);
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h0000) begin
         errors++;
         $display("FAIL clr_write_dropped: vld=%b mem[0]=%h, required 1 0000", a0.vld, a0.dout);
      end
      drv_a0(1, 2'b00, 4'd2, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h0000) begin
         errors++;
         $display("FAIL clr_zeroed: vld=%b mem[2]=%h, required 1 0000", a0.vld, a0.dout);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      drv_a0(1, 2'b11, 4'd9, 16'h9999);
      @(negedge clka);
      drv_a0(1, 2'b00, 4'd9, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a0.dout !== 16'h9999) begin
         errors++;
         $display("FAIL rmc_setup: dout=%h, required 9999", a0.dout);
      end
      clr[0] = 1;
      @(negedge clka);
      clr[0] = 0;
      repeat (8) @(posedge clka);
      // clear counter now at 8
      #1 rst_n = 0;
      @(negedge clka);
      checks++;
      if (busy[0] !== 1'b1 || a0.dout !== 16'h0 || a0.vld !== 1'b0) begin
         errors++;
         $display("FAIL rmc_in_reset: busy=%b dout=%h vld=%b, required 1 0000 0", busy[0],
                  a0.dout, a0.vld);
      end
      @(posedge clka);
      #1 rst_n = 1;
      count_busy(n);
      checks++;
      if (n !== 17) begin
         errors++;
         $display("FAIL rmc_restart_len: busy cycles=%0d, required 17", n);
      end
      drv_a0(1, 2'b00, 4'd9, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a0.vld !== 1'b1 || a0.dout !== 16'h0000) begin
         errors++;
         $display("FAIL rmc_zeroed: vld=%b mem[9]=%h, required 1 0000", a0.vld, a0.dout);
      end
   endtask

   task automatic test_oob();
      drv_a3(1, 2'b11, 4'd5, 16'h5A5A);
      @(negedge clka);
      drv_a3(1, 2'b00, 4'd5, 16'h0);
      @(negedge clka);
      checks++;
      if (a3.vld !== 1'b1 || a3.dout !== 16'h5A5A || oob[3] !== 1'b0) begin
         errors++;
         $display("FAIL oob_setup: vld=%b dout=%h oob=%b, required 1 5a5a 0", a3.vld, a3.dout,
                  oob[3]);
      end
      drv_a3(1, 2'b00, 4'd13, 16'h0);
      @(negedge clka);
      checks++;
      if (oob[3] !== 1'b1 || a3.vld !== 1'b0 || a3.dout !== 16'h5A5A) begin
         errors++;
         $display("FAIL oob_read: oob=%b vld=%b dout=%h, required 1 0 5a5a", oob[3], a3.vld,
                  a3.dout);
      end
      drv_a3(1, 2'b11, 4'd13, 16'hFFFF);
      @(negedge clka);
      idle_all();
      checks++;
      if (oob[3] !== 1'b1 || a3.vld !== 1'b0) begin
         errors++;
         $display("FAIL oob_write: oob=%b vld=%b, required 1 0", oob[3], a3.vld);
      end
      @(negedge clka);
      checks++;
      if (oob[3] !== 1'b0) begin
         errors++;
         $display("FAIL oob_single_pulse: oob=%b, required 0", oob[3]);
      end
      drv_a3(1, 2'b00, 4'd1, 16'h0);
      @(negedge clka);
      checks++;
      if (a3.vld !== 1'b1 || a3.dout !== 16'h0000) begin
         errors++;
         $display("FAIL oob_no_wrap: vld=%b mem[1]=%h, required 1 0000", a3.vld, a3.dout);
      end
      drv_a3(1, 2'b00, 4'd11, 16'h0);
      @(negedge clka);
      idle_all();
      checks++;
      if (a3.vld !== 1'b1 || oob[3] !== 1'b0 || a3.dout !== 16'h0000) begin
         errors++;
         $display("FAIL oob_last_addr: vld=%b oob=%b dout=%h, required 1 0 0000", a3.vld,
                  oob[3], a3.dout);
      end
   endtask

   initial begin
      idle_all();
      test_reset();
      test_byte_lanes();
      test_write_mode();
      test_collision();
      test_clear_interplay();
      test_reset_mid_clear();
      test_oob();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
